// File: rtl/sync2pse_edge_pkg.sv
// Shared helpers for the two-flop CDC synchronizers: per-bit edge decode
// from the current and previous synchronized levels.
package sync2pse_edge_pkg;

  function automatic logic edge_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic edge_fall(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

endpackage

// File: rtl/sync2pse_edge_sync2ps.sv
// Two-flop level synchronizer. Each bit is independent; multi-bit buses
// must be Gray-coded or held stable by the source.
module sync2ps #(
  parameter int unsigned    W = 1,
  parameter logic [W-1:0]   R = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] s1_q;
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] s2_q;
  logic [W-1:0] s1_d;
  logic [W-1:0] s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= R;
      s2_q <= R;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/sync2pse_edge.sv
// Two-flop synchronizer with one-cycle rising/falling strobes of the
// synchronized level; strobes depend on registered state only.
module sync2pse_edge
  import sync2pse_edge_pkg::*;
#(
  parameter int unsigned    W = 1,
  parameter logic [W-1:0]   R = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] pe,
  output logic [W-1:0] ne
);

  logic [W-1:0] s2;
  logic [W-1:0] s3_q;
  logic [W-1:0] s3_d;

  sync2ps #(.W(W), .R(R)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (s2)
  );

  always_comb begin
    s3_d = s2;
  end

  // s3 resets to the same value as s2, so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s3_q <= R;
    else     s3_q <= s3_d;
  end

  always_comb begin
    pe = '0;
    ne = '0;
    for (int i = 0; i < int'(W); i++) begin
      pe[i] = edge_rise(s2[i], s3_q[i]);
      ne[i] = edge_fall(s2[i], s3_q[i]);
    end
  end

  assign q = s2;

endmodule

// File: tb/tb_sync2pse_edge.sv
// Directed checks of sync2pse_edge: reset behaviour for R=0/R=1, latency,
// edge strobes, a per-bit W=4 case and reset asserted mid-transition.
module tb_sync2pse_edge;

  logic       clk = 1'b0;
  logic       rst;
  logic       d0, d1;
  logic [3:0] d4;
  logic       q0, pe0, ne0;
  logic       q1, pe1, ne1;
  logic [3:0] q4, pe4, ne4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync2pse_edge #(.W(1), .R(1'b0)) dut0 (
    .clk(clk), .rst(rst), .d(d0), .q(q0), .pe(pe0), .ne(ne0)
  );
  sync2pse_edge #(.W(1), .R(1'b1)) dut1 (
    .clk(clk), .rst(rst), .d(d1), .q(q1), .pe(pe1), .ne(ne1)
  );
  sync2pse_edge #(.W(4), .R(4'b0000)) dut4 (
    .clk(clk), .rst(rst), .d(d4), .q(q4), .pe(pe4), .ne(ne4)
  );

  typedef struct packed {
    logic d;
    logic q;
    logic pe;
    logic ne;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // dut1 (R=1, d held high) must stay at q=1 with no strobes throughout.
  task automatic chk_r1(input string name);
    chk(name, {1'b0, q1, pe1, ne1}, 4'b0100);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Starting from s1=s2=s3=1 with d toggling, then holding.
    vecs[0]  = '{d:1'b0, q:1'b1, pe:1'b0, ne:1'b0};
    vecs[1]  = '{d:1'b1, q:1'b0, pe:1'b0, ne:1'b1};
    vecs[2]  = '{d:1'b0, q:1'b1, pe:1'b1, ne:1'b0};
    vecs[3]  = '{d:1'b1, q:1'b0, pe:1'b0, ne:1'b1};
    vecs[4]  = '{d:1'b0, q:1'b1, pe:1'b1, ne:1'b0};
    vecs[5]  = '{d:1'b1, q:1'b0, pe:1'b0, ne:1'b1};
    vecs[6]  = '{d:1'b0, q:1'b1, pe:1'b1, ne:1'b0};
    vecs[7]  = '{d:1'b1, q:1'b0, pe:1'b0, ne:1'b1};
    vecs[8]  = '{d:1'b1, q:1'b1, pe:1'b1, ne:1'b0};
    vecs[9]  = '{d:1'b1, q:1'b1, pe:1'b0, ne:1'b0};
    vecs[10] = '{d:1'b0, q:1'b1, pe:1'b0, ne:1'b0};
    vecs[11] = '{d:1'b0, q:1'b0, pe:1'b0, ne:1'b1};
    vecs[12] = '{d:1'b0, q:1'b0, pe:1'b0, ne:1'b0};

    rst = 1'b1;
    d0  = 1'b1;
    d1  = 1'b1;
    d4  = 4'b0000;

    // Held in reset with d high.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_r0", {1'b0, q0, pe0, ne0}, 4'b0000);
      chk_r1("rst_r1");
      chk("rst_w4_q", q4, 4'b0000);
    end

    @(negedge clk) rst = 1'b0;
    step();
    chk("rel_c1", {1'b0, q0, pe0, ne0}, 4'b0000);
    chk_r1("rel_c1_r1");
    step();
    chk("rel_c2", {1'b0, q0, pe0, ne0}, 4'b0110);
    chk_r1("rel_c2_r1");
    step();
    chk("rel_c3", {1'b0, q0, pe0, ne0}, 4'b0100);
    chk_r1("rel_c3_r1");

    // Toggle / hold table.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk) d0 = vecs[i].d;
      step();
      chk($sformatf("vec%0d", i), {1'b0, q0, pe0, ne0},
          {1'b0, vecs[i].q, vecs[i].pe, vecs[i].ne});
      chk($sformatf("vec%0d_pe_and_ne", i), {3'b000, pe0 & ne0}, 4'b0000);
      chk_r1($sformatf("vec%0d_r1", i));
    end

    // d high before posedge 10, low before posedge 20.
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk) d0 = (n >= 10 && n < 20);
      step();
      chk($sformatf("lvl_p%0d", n), {1'b0, q0, pe0, ne0},
          {1'b0, (n >= 11 && n <= 20), (n == 11), (n == 21)});
    end

    // Per-bit independence on the 4-bit instance.
    @(negedge clk) d4 = 4'b1010;
    repeat (3) step();
    chk("w4_settle_q", q4, 4'b1010);
    chk("w4_settle_pe", pe4, 4'b0000);
    chk("w4_settle_ne", ne4, 4'b0000);
    @(negedge clk) d4 = 4'b0101;
    step();
    chk("w4_c1_q", q4, 4'b1010);
    step();
    chk("w4_c2_q", q4, 4'b0101);
    chk("w4_c2_pe", pe4, 4'b0101);
    chk("w4_c2_ne", ne4, 4'b1010);
    step();
    chk("w4_c3_pe", pe4, 4'b0000);
    chk("w4_c3_ne", ne4, 4'b0000);

    // Reset pulse while a 0->1 is in flight (s1 already holds 1).
    @(negedge clk) d0 = 1'b1;
    step();
    chk("mid_pre", {1'b0, q0, pe0, ne0}, 4'b0000);
    #2 rst = 1'b1;
    #1;
    chk("mid_in_rst", {1'b0, q0, pe0, ne0}, 4'b0000);
    chk_r1("mid_in_rst_r1");
    chk("mid_in_rst_w4", q4, 4'b0000);
    @(negedge clk) rst = 1'b0;
    step();
    chk("mid_rel_c1", {1'b0, q0, pe0, ne0}, 4'b0000);
    step();
    chk("mid_rel_c2", {1'b0, q0, pe0, ne0}, 4'b0110);
    chk_r1("mid_rel_c2_r1");
    step();
    chk("mid_rel_c3", {1'b0, q0, pe0, ne0}, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
